// File: rtl/scr1_ialu_rvm_seq.sv
// scr1_ialu_rvm_seq: iterative RV32M multiply/divide unit on the EXU->IALU
// MUL/DIV command handshake.
//
// Radix-2 shift-add multiply (LSB first) and restoring divide (MSB first).
// Divide-by-zero and signed overflow finish in one cycle. All other commands
// take XLEN+2 cycles from accept to the result-ready pulse.
//
// Optional feature:
//   SCR1_IALU_RVM_RADIX4_EN - multiply retires 2 multiplier bits per cycle,
//                             giving a multiply latency of XLEN/2+2.
//
// Ports:
//   clk                    - clock, rising edge
//   rst                    - synchronous active-high reset
//   exu2ialu_rvm_cmd_vd_i  - command valid, held by the EXU until res_rdy
//   exu2ialu_rvm_cmd_i     - 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//   exu2ialu_main_op1_i    - rs1 operand
//   exu2ialu_main_op2_i    - rs2 operand
//   ialu2exu_rvm_res_rdy_o - one-cycle result-ready pulse
//   ialu2exu_main_res_o    - result, held between results
//   ialu2exu_rvm_busy_o    - high while the unit is not idle

`ifndef SCR1_XLEN
`define SCR1_XLEN 32
`endif

module scr1_ialu_rvm_seq #(
  parameter int unsigned XLEN = `SCR1_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exu2ialu_rvm_cmd_vd_i,
  input  logic [2:0]      exu2ialu_rvm_cmd_i,
  input  logic [XLEN-1:0] exu2ialu_main_op1_i,
  input  logic [XLEN-1:0] exu2ialu_main_op2_i,
  output logic            ialu2exu_rvm_res_rdy_o,
  output logic [XLEN-1:0] ialu2exu_main_res_o,
  output logic            ialu2exu_rvm_busy_o
);

  localparam int unsigned CNT_W = $clog2(XLEN);

  localparam logic [2:0] CMD_MUL    = 3'd0;
  localparam logic [2:0] CMD_MULH   = 3'd1;
  localparam logic [2:0] CMD_MULHSU = 3'd2;
  localparam logic [2:0] CMD_MULHU  = 3'd3;
  localparam logic [2:0] CMD_DIV    = 3'd4;
  localparam logic [2:0] CMD_DIVU   = 3'd5;
  localparam logic [2:0] CMD_REM    = 3'd6;
  localparam logic [2:0] CMD_REMU   = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    CORR = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_q;
  state_t            state_d;

  logic [2:0]        cmd_q;
  logic              neg_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   hi_q;     // product high half / partial remainder
  logic [XLEN-1:0]   lo_q;     // multiplier / dividend shifting into quotient
  logic [XLEN-1:0]   mcand_q;  // multiplicand or divisor magnitude

  logic              rdy_q;
  logic              busy_q;
  logic [XLEN-1:0]   res_q;

  logic              vd;
  logic [2:0]        cmd_in;
  logic [XLEN-1:0]   op1;
  logic [XLEN-1:0]   op2;

  assign vd     = exu2ialu_rvm_cmd_vd_i;
  assign cmd_in = exu2ialu_rvm_cmd_i;
  assign op1    = exu2ialu_main_op1_i;
  assign op2    = exu2ialu_main_op2_i;

  // Input decode: signedness, magnitudes, special cases.
  logic              in_is_div;
  logic              in_is_rem;
  logic              op1_signed;
  logic              op2_signed;
  logic              s1;
  logic              s2;
  logic              neg_c;
  logic [XLEN-1:0]   abs1;
  logic [XLEN-1:0]   abs2;
  logic              op2_zero;
  logic              ovf;
  logic              special;
  logic [XLEN-1:0]   spec_res;
  logic [CNT_W-1:0]  cnt_load;

  always_comb begin
    in_is_div  = cmd_in[2];
    in_is_rem  = cmd_in[2] & cmd_in[1];
    op1_signed = 1'b0;
    op2_signed = 1'b0;
    case (cmd_in)
      CMD_MUL, CMD_MULH: begin
        op1_signed = 1'b1;
        op2_signed = 1'b1;
      end
      CMD_MULHSU: op1_signed = 1'b1;
      CMD_DIV, CMD_REM: begin
        op1_signed = 1'b1;
        op2_signed = 1'b1;
      end
      CMD_MULHU, CMD_DIVU, CMD_REMU: begin
        op1_signed = 1'b0;
        op2_signed = 1'b0;
      end
      default: begin
        op1_signed = 1'b0;
        op2_signed = 1'b0;
      end
    endcase

    s1    = op1_signed & op1[XLEN-1];
    s2    = op2_signed & op2[XLEN-1];
    abs1  = s1 ? (XLEN'(0) - op1) : op1;
    abs2  = s2 ? (XLEN'(0) - op2) : op2;
    // Remainder takes the dividend's sign; everything else the sign product.
    neg_c = in_is_rem ? s1 : (s1 ^ s2);

    op2_zero = (op2 == '0);
    ovf      = (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (op2 == '1);
    special  = in_is_div & (op2_zero | (~cmd_in[0] & ovf));
    if (op2_zero) begin
      spec_res = in_is_rem ? op1 : '1;
    end else begin
      spec_res = in_is_rem ? '0 : op1;
    end

`ifdef SCR1_IALU_RVM_RADIX4_EN
    cnt_load = in_is_div ? CNT_W'(XLEN - 1) : CNT_W'(XLEN / 2 - 1);
`else
    cnt_load = CNT_W'(XLEN - 1);
`endif
  end

  // One iteration of the multiply or divide datapath.
  logic [XLEN-1:0]   hi_nxt;
  logic [XLEN-1:0]   lo_nxt;
  logic [XLEN:0]     div_shift;
  logic              div_ge;
`ifdef SCR1_IALU_RVM_RADIX4_EN
  logic [XLEN+1:0]   mul_add;
  logic [XLEN+1:0]   mul_sum;
`else
  logic [XLEN:0]     mul_sum;
`endif

  always_comb begin
    hi_nxt    = hi_q;
    lo_nxt    = lo_q;
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_ge    = (div_shift >= {1'b0, mcand_q});
`ifdef SCR1_IALU_RVM_RADIX4_EN
    case (lo_q[1:0])
      2'd1:    mul_add = {2'b00, mcand_q};
      2'd2:    mul_add = {1'b0, mcand_q, 1'b0};
      2'd3:    mul_add = {2'b00, mcand_q} + {1'b0, mcand_q, 1'b0};
      default: mul_add = '0;
    endcase
    mul_sum = {2'b00, hi_q} + mul_add;
`else
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
`endif

    if (cmd_q[2]) begin
      // Remainder stays below the divisor, so XLEN bits hold the difference.
      hi_nxt = div_ge ? (div_shift[XLEN-1:0] - mcand_q) : div_shift[XLEN-1:0];
      lo_nxt = {lo_q[XLEN-2:0], div_ge};
    end else begin
`ifdef SCR1_IALU_RVM_RADIX4_EN
      hi_nxt = mul_sum[XLEN+1:2];
      lo_nxt = {mul_sum[1:0], lo_q[XLEN-1:2]};
`else
      hi_nxt = mul_sum[XLEN:1];
      lo_nxt = {mul_sum[0], lo_q[XLEN-1:1]};
`endif
    end
  end

  // Sign correction and result selection.
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_c;
  logic [XLEN-1:0]   quo_c;
  logic [XLEN-1:0]   rem_c;
  logic [XLEN-1:0]   corr_res;

  always_comb begin
    prod   = {hi_q, lo_q};
    prod_c = neg_q ? ((2*XLEN)'(0) - prod) : prod;
    quo_c  = neg_q ? (XLEN'(0) - lo_q) : lo_q;
    rem_c  = neg_q ? (XLEN'(0) - hi_q) : hi_q;
    case (cmd_q)
      CMD_MUL:                        corr_res = prod_c[XLEN-1:0];
      CMD_MULH, CMD_MULHSU, CMD_MULHU: corr_res = prod_c[2*XLEN-1:XLEN];
      CMD_DIV, CMD_DIVU:              corr_res = quo_c;
      CMD_REM, CMD_REMU:              corr_res = rem_c;
      default:                        corr_res = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; dropping valid mid-computation aborts.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (vd) begin
          state_d = special ? DONE : CALC;
        end
      end
      CALC: begin
        if (!vd) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = CORR;
        end
      end
      CORR:    state_d = vd ? DONE : IDLE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output next values, registered below.
  logic              rdy_d;
  logic              busy_d;
  logic [XLEN-1:0]   res_d;

  always_comb begin
    rdy_d  = (state_d == DONE);
    busy_d = (state_d != IDLE);
    res_d  = res_q;
    if ((state_q == IDLE) && vd && special) begin
      res_d = spec_res;
    end else if ((state_q == CORR) && vd) begin
      res_d = corr_res;
    end
  end

  // Output and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      res_q   <= '0;
      cmd_q   <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
    end else begin
      rdy_q  <= rdy_d;
      busy_q <= busy_d;
      res_q  <= res_d;
      case (state_q)
        IDLE: begin
          if (vd) begin
            cmd_q <= cmd_in;
            neg_q <= neg_c;
            cnt_q <= cnt_load;
            hi_q  <= '0;
            if (in_is_div) begin
              lo_q    <= abs1;
              mcand_q <= abs2;
            end else begin
              lo_q    <= abs2;
              mcand_q <= abs1;
            end
          end
        end
        CALC: begin
          cnt_q <= cnt_q - CNT_W'(1);
          hi_q  <= hi_nxt;
          lo_q  <= lo_nxt;
        end
        default: begin
        end
      endcase
    end
  end

  assign ialu2exu_rvm_res_rdy_o = rdy_q;
  assign ialu2exu_rvm_busy_o    = busy_q;
  assign ialu2exu_main_res_o    = res_q;

endmodule

// File: tb/tb_scr1_ialu_rvm_seq.sv
// Testbench for scr1_ialu_rvm_seq (XLEN=32): directed cases, abort, reset,
// back-to-back, and randomized commands against a behavioural model.
module tb_scr1_ialu_rvm_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        vd;
  logic [2:0]  cmd;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        rdy;
  logic [31:0] res;
  logic        busy;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  scr1_ialu_rvm_seq #(.XLEN(32)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .exu2ialu_rvm_cmd_vd_i  (vd),
    .exu2ialu_rvm_cmd_i     (cmd),
    .exu2ialu_main_op1_i    (op1),
    .exu2ialu_main_op2_i    (op2),
    .ialu2exu_rvm_res_rdy_o (rdy),
    .ialu2exu_main_res_o    (res),
    .ialu2exu_rvm_busy_o    (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // RISC-V M-extension semantics from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] c, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    logic [63:0]     p;
    int              ia;
    int              ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = $signed(a);
    ib = $signed(b);
    case (c)
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * longint'(ub)); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(ia / ib);
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(ia % ib);
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    if (c[2] && (b == 0 || (!c[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
`ifdef SCR1_IALU_RVM_RADIX4_EN
    if (!c[2]) return 18;
`endif
    return 34;
  endfunction

  // Issue one command from an IDLE cycle and follow it to its result pulse.
  task automatic run_op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                        input bit keep_vd, input bit scramble, input string tag);
    int          n;
    bit          got;
    bit          busy_ok;
    logic [31:0] exp;
    exp = ref_model(c, a, b);
    @(negedge clk);
    cmd = c; op1 = a; op2 = b; vd = 1'b1;
    n = 0; got = 0; busy_ok = 1;
    while (!got && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (busy !== 1'b1) busy_ok = 0;
      if (rdy === 1'b1) got = 1;
      else if (scramble) begin
        op1 = $urandom; op2 = $urandom; cmd = 3'($urandom_range(0, 7));
      end
    end
    chk({tag, " latency"}, 64'(n), 64'(ref_lat(c, a, b)));
    chk({tag, " result"}, 64'(res), 64'(exp));
    chk({tag, " busy"}, 64'(busy_ok), 64'd1);
    if (!keep_vd) vd = 1'b0;
    @(posedge clk); #1;
    chk({tag, " pulse_len"}, 64'(rdy), 64'd0);
    chk({tag, " idle_busy"}, 64'(busy), 64'd0);
    chk({tag, " hold"}, 64'(res), 64'(exp));
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int          n;
    bit          seen;
    logic [31:0] prev;

    rst = 1'b1; vd = 1'b0; cmd = '0; op1 = '0; op2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset rdy", 64'(rdy), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset res", 64'(res), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 0, 0, "MUL");
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0, 0, "MULH");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, "MULHU");
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, "MULHSU");
    run_op(3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 0, 0, "DIV");
    run_op(3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 0, 0, "REM");
    run_op(3'd5, 32'd100, 32'd7, 0, 0, "DIVU");
    run_op(3'd7, 32'd100, 32'd7, 0, 0, "REMU");
    run_op(3'd5, 32'd5, 32'd0, 0, 0, "DIVU0");
    run_op(3'd6, 32'd5, 32'd0, 0, 0, "REM0");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, "DIVOVF");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, "REMOVF");

    // Abort: valid dropped during cycle A+10.
    prev = res;
    @(negedge clk);
    cmd = 3'd5; op1 = 32'd1000; op2 = 32'd3; vd = 1'b1;
    seen = 0;
    for (n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      if (rdy === 1'b1) seen = 1;
    end
    vd = 1'b0;
    @(posedge clk); #1;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort res", 64'(res), 64'(prev));
    repeat (40) begin
      @(posedge clk); #1;
      if (rdy === 1'b1) seen = 1;
    end
    chk("abort no_pulse", 64'(seen), 64'd0);

    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, "MULHU_after_abort");

    // Reset during cycle A+5 of a MUL.
    @(negedge clk);
    cmd = 3'd0; op1 = 32'h1234_5678; op2 = 32'h9ABC_DEF0; vd = 1'b1;
    seen = 0;
    for (n = 1; n <= 5; n++) begin
      @(posedge clk); #1;
      if (rdy === 1'b1) seen = 1;
    end
    rst = 1'b1; vd = 1'b0;
    @(posedge clk); #1;
    chk("rst rdy", 64'(rdy), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst res", 64'(res), 64'd0);
    rst = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (rdy === 1'b1) seen = 1;
    end
    chk("rst no_pulse", 64'(seen), 64'd0);

    // Back-to-back: valid held across DONE, new command in the IDLE cycle.
    run_op(3'd7, 32'd100, 32'd7, 1, 0, "B2B_first");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0, 0, "B2B_second");

    // Randomized commands; operands and cmd scrambled after accept.
    for (int c = 0; c < 8; c++) begin
      for (int k = 0; k < 30; k++) begin
        run_op(3'(c), pick_operand(), pick_operand(), 0, 1, $sformatf("rand_c%0d_%0d", c, k));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
